// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the mc_ctrl multi-cycle controller: state encoding,
// opcode map, ALU operand-mode codes and parameter defaults.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_START0    = 4'd0,
        ST_START1    = 4'd1,
        ST_FETCH     = 4'd2,
        ST_DECODE    = 4'd3,
        ST_EXECUTE   = 4'd4,
        ST_MEM       = 4'd5,
        ST_WRITEBACK = 4'd6,
        ST_HALT      = 4'd7,
        ST_FAULT     = 4'd8
    } state_t;

    localparam int unsigned OP_NOOP = 0;
    localparam int unsigned OP_LOD  = 1;
    localparam int unsigned OP_STR  = 2;
    localparam int unsigned OP_BRA  = 4;
    localparam int unsigned OP_BRR  = 5;
    localparam int unsigned OP_BNE  = 6;
    localparam int unsigned OP_ALU  = 8;
    localparam int unsigned OP_HLT  = 15;

    localparam int unsigned AM_IMM_DEF   = 8;
    localparam int unsigned MAX_WAIT_DEF = 15;

    localparam logic [1:0] ALU_REG = 2'b00;
    localparam logic [1:0] ALU_IMM = 2'b01;
    localparam logic [1:0] ALU_RSV = 2'b10;

endpackage

// File: rtl/mc_ctrl_mem_wait.sv
// MEM-phase wait counter: counts un-acknowledged, un-stalled MEM cycles and
// flags a timeout on the cycle that would reach MAX_WAIT (an ACK that cycle wins).
module mc_ctrl_mem_wait #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic ack,
    input  logic stall,
    output logic timeout
);

    localparam int unsigned CW = 8;

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!en) begin
            count <= '0;
        end else if (!stall && !ack) begin
            count <= count + 8'd1;
        end
    end

    assign timeout = en && !stall && !ack && (count == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle CPU control FSM driving PC, register file, ALU and data memory.
// Define MC_CTRL_SKIP_MEM_EN to let non-memory instructions bypass the MEM state.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned OPW      = 4,
    parameter int unsigned MMW      = 4,
    parameter int unsigned AM_IMM   = AM_IMM_DEF,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [OPW-1:0] OPCODE,
    input  logic [MMW-1:0] MM,
    input  logic [MMW-1:0] STAT,
    input  logic           STALL,
    input  logic           MEM_ACK,
    output logic           RF_WE,
    output logic [1:0]     ALU_OP,
    output logic           WB_SEL,
    output logic           RD_SEL,
    output logic           PC_SEL,
    output logic           PC_WRITE,
    output logic           PC_RST,
    output logic           BR_SEL,
    output logic           MEM_REQ,
    output logic           MEM_WE,
    output logic           HALTED,
    output logic           FAULT,
    output logic [3:0]     STATE
);

    state_t         state;
    logic [OPW-1:0] op_q;
    logic [MMW-1:0] mm_q;

    logic opcode_legal;
    logic is_load, is_store, is_alu, is_mem_op;
    logic is_branch, is_abs_br, taken;
    logic mem_en, timeout;

    assign opcode_legal = (OPCODE == OPW'(OP_NOOP)) || (OPCODE == OPW'(OP_LOD)) ||
                          (OPCODE == OPW'(OP_STR))  || (OPCODE == OPW'(OP_BRA)) ||
                          (OPCODE == OPW'(OP_BRR))  || (OPCODE == OPW'(OP_BNE)) ||
                          (OPCODE == OPW'(OP_ALU));

    assign is_load   = (op_q == OPW'(OP_LOD));
    assign is_store  = (op_q == OPW'(OP_STR));
    assign is_alu    = (op_q == OPW'(OP_ALU));
    assign is_mem_op = is_load || is_store;
    assign is_abs_br = (op_q == OPW'(OP_BRA)) || (op_q == OPW'(OP_BNE));
    assign is_branch = is_abs_br || (op_q == OPW'(OP_BRR));
    // A zero mask makes the branch unconditional.
    assign taken     = is_branch && ((mm_q & STAT) == mm_q);
    assign mem_en    = (state == ST_MEM) && is_mem_op;

    mc_ctrl_mem_wait #(
        .MAX_WAIT(MAX_WAIT)
    ) u_mem_wait (
        .clk    (CLK),
        .rst    (RST),
        .en     (mem_en),
        .ack    (MEM_ACK),
        .stall  (STALL),
        .timeout(timeout)
    );

    // HALT and FAULT self-loop, so gating on STALL leaves them unaffected.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_START0;
            op_q  <= '0;
            mm_q  <= '0;
        end else if (!STALL) begin
            case (state)
                ST_START0: state <= ST_START1;
                ST_START1: state <= ST_FETCH;
                ST_FETCH:  state <= ST_DECODE;
                ST_DECODE: begin
                    op_q <= OPCODE;
                    mm_q <= MM;
                    if (OPCODE == OPW'(OP_HLT)) begin
                        state <= ST_HALT;
                    end else if (opcode_legal) begin
                        state <= ST_EXECUTE;
                    end else begin
                        state <= ST_FAULT;
                    end
                end
                ST_EXECUTE: begin
`ifdef MC_CTRL_SKIP_MEM_EN
                    if (is_mem_op) begin
                        state <= ST_MEM;
                    end else if (is_alu) begin
                        state <= ST_WRITEBACK;
                    end else begin
                        state <= ST_FETCH;
                    end
`else
                    state <= ST_MEM;
`endif
                end
                ST_MEM: begin
                    if (!is_mem_op || MEM_ACK) begin
                        state <= ST_WRITEBACK;
                    end else if (timeout) begin
                        state <= ST_FAULT;
                    end
                end
                ST_WRITEBACK: state <= ST_FETCH;
                ST_HALT:      state <= ST_HALT;
                ST_FAULT:     state <= ST_FAULT;
                default:      state <= ST_FAULT;
            endcase
        end
    end

    always_comb begin
        RF_WE    = 1'b0;
        ALU_OP   = ALU_REG;
        WB_SEL   = 1'b0;
        RD_SEL   = 1'b0;
        PC_SEL   = 1'b0;
        PC_WRITE = 1'b0;
        PC_RST   = 1'b0;
        BR_SEL   = 1'b0;
        MEM_REQ  = 1'b0;
        MEM_WE   = 1'b0;
        HALTED   = 1'b0;
        FAULT    = 1'b0;
        case (state)
            ST_START0: PC_RST = 1'b1;
            ST_FETCH:  PC_WRITE = !STALL;
            ST_EXECUTE: begin
                if (mm_q == '0) begin
                    ALU_OP = ALU_REG;
                end else if (mm_q == MMW'(AM_IMM)) begin
                    ALU_OP = ALU_IMM;
                end else begin
                    ALU_OP = ALU_RSV;
                end
                BR_SEL = is_abs_br;
                if (taken) begin
                    PC_SEL   = 1'b1;
                    PC_WRITE = !STALL;
                end
            end
            ST_MEM: begin
                if (is_mem_op) begin
                    MEM_REQ = !STALL;
                    MEM_WE  = is_store;
                end
            end
            ST_WRITEBACK: begin
                if (is_alu || is_load) begin
                    RF_WE  = !STALL;
                    WB_SEL = is_load;
                    RD_SEL = 1'b1;
                end
            end
            ST_HALT:  HALTED = 1'b1;
            ST_FAULT: FAULT = 1'b1;
            default: ;
        endcase
    end

    assign STATE = state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed scenarios plus randomized
// instruction streams compared against an instruction-level reference model.
module tb_mc_ctrl;
    import mc_ctrl_pkg::*;

    localparam int unsigned MAX_WAIT = 15;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [3:0] OPCODE = '0;
    logic [3:0] MM = '0;
    logic [3:0] STAT = '0;
    logic       STALL = 1'b0;
    logic       MEM_ACK = 1'b0;
    logic       RF_WE, WB_SEL, RD_SEL, PC_SEL, PC_WRITE, PC_RST, BR_SEL;
    logic       MEM_REQ, MEM_WE, HALTED, FAULT;
    logic [1:0] ALU_OP;
    logic [3:0] STATE;

    int checks = 0;
    int errors = 0;

    logic [3:0] cur_op = '0;
    logic [3:0] cur_mm = '0;
    state_t     stall_ph = ST_START0;
    int unsigned stall_len = 0;

    logic [12:0] obs;
    assign obs = {RF_WE, ALU_OP, WB_SEL, RD_SEL, PC_SEL, PC_WRITE, PC_RST,
                  BR_SEL, MEM_REQ, MEM_WE, HALTED, FAULT};

    mc_ctrl #(
        .OPW(4), .MMW(4), .AM_IMM(8), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .MM(MM), .STAT(STAT),
        .STALL(STALL), .MEM_ACK(MEM_ACK), .RF_WE(RF_WE), .ALU_OP(ALU_OP),
        .WB_SEL(WB_SEL), .RD_SEL(RD_SEL), .PC_SEL(PC_SEL), .PC_WRITE(PC_WRITE),
        .PC_RST(PC_RST), .BR_SEL(BR_SEL), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
        .HALTED(HALTED), .FAULT(FAULT), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    // Expected control word for one phase of an instruction.
    function automatic logic [12:0] expect_out(input state_t ph, input logic [3:0] op,
                                               input logic [3:0] mm, input logic [3:0] stat,
                                               input logic stall);
        logic rf_we, wb_sel, rd_sel, pc_sel, pc_write, pc_rst, br_sel;
        logic mem_req, mem_we, halted, fault;
        logic [1:0] alu_op;
        logic branch, memop;
        {rf_we, wb_sel, rd_sel, pc_sel, pc_write, pc_rst, br_sel} = '0;
        {mem_req, mem_we, halted, fault} = '0;
        alu_op = 2'b00;
        branch = (op == 4) || (op == 5) || (op == 6);
        memop  = (op == 1) || (op == 2);
        case (ph)
            ST_START0: pc_rst = 1'b1;
            ST_FETCH:  pc_write = !stall;
            ST_EXECUTE: begin
                alu_op = (mm == 0) ? 2'b00 : (mm == 8) ? 2'b01 : 2'b10;
                br_sel = (op == 4) || (op == 6);
                if (branch && ((stat | ~mm) == 4'hF)) begin
                    pc_sel   = 1'b1;
                    pc_write = !stall;
                end
            end
            ST_MEM: if (memop) begin
                mem_req = !stall;
                mem_we  = (op == 2);
            end
            ST_WRITEBACK: if (op == 8 || op == 1) begin
                rf_we  = !stall;
                wb_sel = (op == 1);
                rd_sel = 1'b1;
            end
            ST_HALT:  halted = 1'b1;
            ST_FAULT: fault = 1'b1;
            default: ;
        endcase
        return {rf_we, alu_op, wb_sel, rd_sel, pc_sel, pc_write, pc_rst,
                br_sel, mem_req, mem_we, halted, fault};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle in phase ph: apply inputs, check, advance past the edge.
    task automatic cyc(input state_t ph, input logic stall, input logic ack, input string tag);
        STALL   = stall;
        MEM_ACK = ack;
        #2;
        chk({tag, "/state"}, 32'(STATE), 32'(ph));
        chk({tag, "/outs"}, 32'(obs), 32'(expect_out(ph, cur_op, cur_mm, STAT, stall)));
        @(posedge CLK);
        #1;
    endtask

    // Phase with an optional one-shot stall burst in front of it.
    task automatic phase(input state_t ph, input logic ack, input string tag);
        if (ph == stall_ph && stall_len > 0) begin
            repeat (stall_len) cyc(ph, 1'b1, 1'b0, {tag, "/stall"});
            stall_len = 0;
        end
        cyc(ph, 1'b0, ack, tag);
    endtask

    task automatic do_reset(input string tag);
        RST = 1'b1;
        STALL = 1'b0;
        MEM_ACK = 1'b0;
        #1;
        chk({tag, "/rst_state"}, 32'(STATE), 32'(ST_START0));
        chk({tag, "/rst_outs"}, 32'(obs), 32'(expect_out(ST_START0, cur_op, cur_mm, STAT, 1'b0)));
        @(posedge CLK);
        #1;
        RST = 1'b0;
        cyc(ST_START0, 1'b0, 1'b0, {tag, "/start0"});
        cyc(ST_START1, 1'b0, 1'b0, {tag, "/start1"});
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [3:0] mm, input logic [3:0] stat,
                             input int unsigned ack_wait, input string tag);
        cur_op = op;
        cur_mm = mm;
        OPCODE = op;
        MM     = mm;
        STAT   = stat;
        phase(ST_FETCH, 1'b0, {tag, "/fetch"});
        phase(ST_DECODE, 1'b0, {tag, "/decode"});
        OPCODE = 4'($urandom);
        MM     = 4'($urandom);
        phase(ST_EXECUTE, 1'b0, {tag, "/exec"});
`ifdef MC_CTRL_SKIP_MEM_EN
        if (op == 1 || op == 2) begin
            for (int i = 0; i < int'(ack_wait); i++) phase(ST_MEM, 1'b0, {tag, "/mem_wait"});
            phase(ST_MEM, 1'b1, {tag, "/mem_ack"});
            phase(ST_WRITEBACK, 1'b0, {tag, "/wb"});
        end else if (op == 8) begin
            phase(ST_WRITEBACK, 1'b0, {tag, "/wb"});
        end
`else
        if (op == 1 || op == 2) begin
            for (int i = 0; i < int'(ack_wait); i++) phase(ST_MEM, 1'b0, {tag, "/mem_wait"});
            phase(ST_MEM, 1'b1, {tag, "/mem_ack"});
        end else begin
            phase(ST_MEM, 1'($urandom), {tag, "/mem"});
        end
        phase(ST_WRITEBACK, 1'b0, {tag, "/wb"});
`endif
        stall_len = 0;
    endtask

    initial begin
        logic [3:0] ops [7];
        state_t     sph [5];
        ops = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd8};
        sph = '{ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEM, ST_WRITEBACK};

        #2;
        do_reset("init");

        run_instr(4'd8, 4'd8, 4'd0, 0, "alu_imm");
        run_instr(4'd8, 4'd0, 4'd0, 0, "alu_reg");
        run_instr(4'd6, 4'b0011, 4'b0111, 0, "bne_taken");
        run_instr(4'd6, 4'b0011, 4'b0101, 0, "bne_not_taken");
        run_instr(4'd5, 4'b0000, 4'b0000, 0, "brr_uncond");
        run_instr(4'd1, 4'd0, 4'd0, 3, "lod_ack3");
        run_instr(4'd2, 4'd3, 4'd0, 0, "str_ack0");
        run_instr(4'd1, 4'd0, 4'd0, MAX_WAIT - 1, "lod_ack_at_limit");

        stall_ph = ST_EXECUTE;
        stall_len = 5;
        run_instr(4'd8, 4'd2, 4'd0, 0, "alu_stall_exec");
        stall_ph = ST_MEM;
        stall_len = 3;
        run_instr(4'd2, 4'd0, 4'd0, 2, "str_stall_mem");

        // Reset while a load holds MEM_REQ high.
        cur_op = 4'd1; cur_mm = 4'd0; OPCODE = 4'd1; MM = 4'd0;
        cyc(ST_FETCH, 1'b0, 1'b0, "rstmem/fetch");
        cyc(ST_DECODE, 1'b0, 1'b0, "rstmem/decode");
        cyc(ST_EXECUTE, 1'b0, 1'b0, "rstmem/exec");
        STALL = 1'b0; MEM_ACK = 1'b0;
        #2;
        chk("rstmem/req_before", 32'(MEM_REQ), 32'd1);
        do_reset("rstmem");

        // Load timeout with a stall burst that must freeze the wait count.
        cur_op = 4'd1; cur_mm = 4'd0; OPCODE = 4'd1; MM = 4'd0;
        cyc(ST_FETCH, 1'b0, 1'b0, "tmo/fetch");
        cyc(ST_DECODE, 1'b0, 1'b0, "tmo/decode");
        cyc(ST_EXECUTE, 1'b0, 1'b0, "tmo/exec");
        for (int i = 0; i < 7; i++) cyc(ST_MEM, 1'b0, 1'b0, "tmo/mem_a");
        cyc(ST_MEM, 1'b1, 1'b0, "tmo/mem_stall");
        cyc(ST_MEM, 1'b1, 1'b0, "tmo/mem_stall");
        for (int i = 7; i < int'(MAX_WAIT); i++) cyc(ST_MEM, 1'b0, 1'b0, "tmo/mem_b");
        for (int i = 0; i < 6; i++) cyc(ST_FAULT, 1'($urandom), 1'($urandom), "tmo/fault");
        do_reset("tmo");

        // Halt is sticky and ignores STALL.
        cur_op = 4'd15; cur_mm = 4'd0; OPCODE = 4'd15; MM = 4'd0;
        cyc(ST_FETCH, 1'b0, 1'b0, "hlt/fetch");
        cyc(ST_DECODE, 1'b0, 1'b0, "hlt/decode");
        OPCODE = 4'd8;
        for (int i = 0; i < 20; i++) cyc(ST_HALT, 1'($urandom), 1'($urandom), "hlt/halt");
        do_reset("hlt");

        cur_op = 4'd3; OPCODE = 4'd3;
        cyc(ST_FETCH, 1'b0, 1'b0, "ill/fetch");
        cyc(ST_DECODE, 1'b0, 1'b0, "ill/decode");
        for (int i = 0; i < 4; i++) cyc(ST_FAULT, 1'($urandom), 1'b0, "ill/fault");
        do_reset("ill");

        for (int n = 0; n < 60; n++) begin
            logic [3:0] mm;
            case ($urandom_range(3, 0))
                0:       mm = 4'd0;
                1:       mm = 4'd8;
                default: mm = 4'($urandom);
            endcase
            if ($urandom_range(1, 0) == 1) begin
                stall_ph  = sph[$urandom_range(4, 0)];
                stall_len = $urandom_range(4, 1);
            end
            run_instr(ops[$urandom_range(6, 0)], mm, 4'($urandom),
                      $urandom_range(6, 0), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
